// File: rtl/ltc2666_spi_responder.sv
// LTC2666-16 SPI responder: oversampled mode-0 slave that decodes 24-bit
// command frames into shadow input/DAC registers for 8 channels and echoes
// the previous legal frame on SDO.
module ltc2666_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] RESET_CODE  = 16'h8000,
  parameter int unsigned FRAME_BITS  = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sck,
  input  logic               cs_n,
  input  logic               sdi,
  output logic               sdo,
  output logic signed [15:0] dac [0:7],
  output logic [7:0]         pd,
  output logic               frame_valid,
  output logic [3:0]         frame_cmd,
  output logic [3:0]         frame_addr,
  output logic [15:0]        frame_data,
  output logic               frame_err,
  output logic [7:0]         err_count
);

  localparam int unsigned NCH       = 8;
  localparam int unsigned WORD_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Synchronizer chains; the newest sample enters at bit 0.
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_prev_q, cs_prev_q;

  logic sck_s, cs_s, sdi_s;
  logic sck_rise, sck_fall, cs_fall, cs_rise;

  state_e               state_q, state_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] sdo_shift_q, sdo_shift_d;
  logic [WORD_BITS-1:0] echo_q, echo_d;
  logic [15:0]          in_q [NCH];
  logic [15:0]          in_d [NCH];
  logic [15:0]          dac_q [NCH];
  logic [15:0]          dac_d [NCH];
  logic [7:0]           pd_q, pd_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [3:0]           frame_cmd_q, frame_cmd_d;
  logic [3:0]           frame_addr_q, frame_addr_d;
  logic [15:0]          frame_data_q, frame_data_d;
  logic [7:0]           err_count_q, err_count_d;

  logic [3:0]  w_cmd;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic [2:0]  ch;
  logic        single_ok;

  // Next value of the synchronizer chains.
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
  end

  // Edge detection on the synchronized pins; sck edges only count while selected.
  always_comb begin
    sck_s    = sck_sync_q[SYNC_STAGES-1];
    cs_s     = cs_sync_q[SYNC_STAGES-1];
    sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    sck_rise = sck_s & ~sck_prev_q & ~cs_s;
    sck_fall = ~sck_s & sck_prev_q & ~cs_s;
    cs_fall  = ~cs_s & cs_prev_q;
    cs_rise  = cs_s & ~cs_prev_q;
  end

  // Frame FSM, shifters and command decode.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    sdo_shift_d   = sdo_shift_q;
    echo_d        = echo_q;
    pd_d          = pd_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    frame_cmd_d   = frame_cmd_q;
    frame_addr_d  = frame_addr_q;
    frame_data_d  = frame_data_q;
    err_count_d   = err_count_q;
    for (int i = 0; i < NCH; i++) begin
      in_d[i]  = in_q[i];
      dac_d[i] = dac_q[i];
    end

    // NOTE: combinational logic uses blocking '=' so later statements see the updated values.
    w_cmd     = shift_q[23:20];
    w_addr    = shift_q[19:16];
    w_data    = shift_q[15:0];
    ch        = w_addr[2:0];
    single_ok = ~w_addr[3];

    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_SHIFT;
          bit_cnt_d   = '0;
          shift_d     = '0;
          sdo_shift_d = echo_q;
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_DONE;
        end else begin
          if (sck_rise) begin
            shift_d = {shift_q[WORD_BITS-2:0], sdi_s};
            if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
          end
          if (sck_fall) sdo_shift_d = {sdo_shift_q[WORD_BITS-2:0], 1'b0};
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        sdo_shift_d = '0;
        if (bit_cnt_q == 5'(FRAME_BITS)) begin
          frame_valid_d = 1'b1;
          frame_cmd_d   = w_cmd;
          frame_addr_d  = w_addr;
          frame_data_d  = w_data;
          echo_d        = shift_q;
          unique case (w_cmd)
            4'b0000: if (single_ok) in_d[ch] = w_data;
            4'b1000: for (int i = 0; i < NCH; i++) in_d[i] = w_data;
            4'b0001: if (single_ok) begin
              dac_d[ch] = in_q[ch];
              pd_d[ch]  = 1'b0;
            end
            4'b1001: begin
              for (int i = 0; i < NCH; i++) dac_d[i] = in_q[i];
              pd_d = 8'h00;
            end
            4'b0011: if (single_ok) begin
              in_d[ch]  = w_data;
              dac_d[ch] = w_data;
              pd_d[ch]  = 1'b0;
            end
            4'b1010: begin
              for (int i = 0; i < NCH; i++) begin
                in_d[i]  = w_data;
                dac_d[i] = w_data;
              end
              pd_d = 8'h00;
            end
            4'b0100: if (single_ok) pd_d[ch] = 1'b1;
            4'b0101: pd_d = 8'hFF;
            default: ;
          endcase
        end else begin
          frame_err_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
        // A new frame may start while the previous one is being retired;
        // it echoes the word captured in this same cycle.
        if (cs_fall) begin
          state_d     = ST_SHIFT;
          bit_cnt_d   = '0;
          shift_d     = '0;
          sdo_shift_d = echo_d;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and register bank, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
    if (!rst) begin
      sck_sync_q    <= '0;
      cs_sync_q     <= '1;
      sdi_sync_q    <= '0;
      sck_prev_q    <= 1'b0;
      cs_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      sdo_shift_q   <= '0;
      echo_q        <= '0;
      pd_q          <= 8'h00;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cmd_q   <= '0;
      frame_addr_q  <= '0;
      frame_data_q  <= '0;
      err_count_q   <= '0;
      // NOTE: the channel arrays are small flop banks, not RAM, so they are reset like any other state.
      for (int i = 0; i < NCH; i++) begin
        in_q[i]  <= RESET_CODE;
        dac_q[i] <= RESET_CODE;
      end
    end else begin
      sck_sync_q    <= sck_sync_d;
      cs_sync_q     <= cs_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      sck_prev_q    <= sck_s;
      cs_prev_q     <= cs_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      sdo_shift_q   <= sdo_shift_d;
      echo_q        <= echo_d;
      pd_q          <= pd_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_addr_q  <= frame_addr_d;
      frame_data_q  <= frame_data_d;
      err_count_q   <= err_count_d;
      for (int i = 0; i < NCH; i++) begin
        in_q[i]  <= in_d[i];
        dac_q[i] <= dac_d[i];
      end
    end
  end

  // Output mapping; the DAC codes are presented as signed values.
  always_comb begin
    sdo         = sdo_shift_q[WORD_BITS-1];
    pd          = pd_q;
    frame_valid = frame_valid_q;
    frame_err   = frame_err_q;
    frame_cmd   = frame_cmd_q;
    frame_addr  = frame_addr_q;
    frame_data  = frame_data_q;
    err_count   = err_count_q;
    for (int i = 0; i < NCH; i++) dac[i] = dac_q[i];
  end

endmodule

// File: tb/tb_ltc2666_spi_responder.sv
// Testbench for ltc2666_spi_responder: directed and random SPI frames
// checked against a frame-level behavioural model of the LTC2666 command set.
module tb_ltc2666_spi_responder;

  localparam int HALF = 5;  // clk cycles per SCK half period

  logic               clk = 1'b0;
  logic               rst;
  logic               sck;
  logic               cs_n;
  logic               sdi;
  logic               sdo;
  logic signed [15:0] dac [0:7];
  logic [7:0]         pd;
  logic               frame_valid;
  logic [3:0]         frame_cmd;
  logic [3:0]         frame_addr;
  logic [15:0]        frame_data;
  logic               frame_err;
  logic [7:0]         err_count;

  ltc2666_spi_responder dut (
    .clk        (clk),
    .rst        (rst),
    .sck        (sck),
    .cs_n       (cs_n),
    .sdi        (sdi),
    .sdo        (sdo),
    .dac        (dac),
    .pd         (pd),
    .frame_valid(frame_valid),
    .frame_cmd  (frame_cmd),
    .frame_addr (frame_addr),
    .frame_data (frame_data),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [15:0] in_m  [8];
  logic [15:0] dac_m [8];
  logic [7:0]  pd_m;
  logic [7:0]  err_m;
  logic [23:0] echo_m;
  logic [3:0]  cmd_m;
  logic [3:0]  addr_m;
  logic [15:0] data_m;

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          settled  = 0;
  int          vcnt     = 0;
  int          ecnt     = 0;
  logic [63:0] last_got;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      in_m[i]  = 16'h8000;
      dac_m[i] = 16'h8000;
    end
    pd_m = 0; err_m = 0; echo_m = 0; cmd_m = 0; addr_m = 0; data_m = 0;
  endtask

  // Apply one completed frame to the model. nbits < 0 means a CS glitch.
  task automatic model_frame(input int nbits, input logic [23:0] w);
    logic [3:0]  c, a;
    logic [15:0] d;
    bit          all;
    bit          tgt [8];
    if (nbits != 24) begin
      err_m = (err_m == 255) ? err_m : err_m + 1;
      return;
    end
    c = w[23:20]; a = w[19:16]; d = w[15:0];
    cmd_m = c; addr_m = a; data_m = d; echo_m = w;
    all = c[3];
    for (int i = 0; i < 8; i++) tgt[i] = all || (a == i);
    case (c)
      4'h0, 4'h8: for (int i = 0; i < 8; i++) if (tgt[i]) in_m[i] = d;
      4'h1, 4'h9: for (int i = 0; i < 8; i++) if (tgt[i]) begin dac_m[i] = in_m[i]; pd_m[i] = 0; end
      4'h3, 4'hA: for (int i = 0; i < 8; i++) if (tgt[i]) begin in_m[i] = d; dac_m[i] = d; pd_m[i] = 0; end
      4'h4:       for (int i = 0; i < 8; i++) if (tgt[i]) pd_m[i] = 1;
      4'h5:       pd_m = 8'hFF;
      default: ;
    endcase
  endtask

  // Drive one SPI transaction; sdo is captured just before each rising sck.
  task automatic send(input int nbits, input logic [63:0] w, output logic [63:0] got);
    got = 0;
    @(negedge clk);
    if (nbits < 0) begin
      cs_n = 0;
      @(negedge clk);
      cs_n = 1;
      return;
    end
    cs_n = 0;
    for (int i = 0; i < nbits; i++) begin
      sdi = w[nbits-1-i];
      repeat (HALF) @(negedge clk);
      got = {got[62:0], sdo};
      sck = 1;
      repeat (HALF) @(negedge clk);
      sck = 0;
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1;
  endtask

  task automatic do_frame(input int nbits, input logic [63:0] w);
    logic [63:0] got, exp_sdo;
    int          v0, e0;
    bit          legal;
    exp_sdo = 0;
    for (int i = 0; i < nbits; i++) exp_sdo[nbits-1-i] = (i < 24) ? echo_m[23-i] : 1'b0;
    v0 = vcnt; e0 = ecnt;
    legal = (nbits == 24);
    send(nbits, w, got);
    last_got = got;
    repeat (8) @(negedge clk);
    model_frame(nbits, w[23:0]);
    check("sdo_echo", got, exp_sdo);
    check("valid_pulses", vcnt - v0, legal ? 1 : 0);
    check("err_pulses", ecnt - e0, legal ? 0 : 1);
    settled = 1;
    repeat (3) @(negedge clk);
    settled = 0;
  endtask

  // Strobe counters
  always @(posedge clk) begin
    #2;
    if (frame_valid === 1'b1) vcnt++;
    if (frame_err === 1'b1) ecnt++;
  end

  // Compare DUT against the model whenever a frame has been retired
  always @(posedge clk) begin
    #2;
    if (settled) begin
      for (int i = 0; i < 8; i++) check($sformatf("dac%0d", i), {48'h0, dac[i]}, {48'h0, dac_m[i]});
      check("pd", pd, pd_m);
      check("err_count", err_count, err_m);
      check("frame_cmd", frame_cmd, cmd_m);
      check("frame_addr", frame_addr, addr_m);
      check("frame_data", frame_data, data_m);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cmds [9];
    logic [3:0] c;
    int         nb;
    cmds = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'h0};

    rst = 0; sck = 0; cs_n = 1; sdi = 0;
    model_reset();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) check("reset_dac", {48'h0, dac[i]}, 64'h8000);
    check("reset_pd", pd, 0);
    check("reset_sdo", sdo, 0);
    check("reset_err_count", err_count, 0);
    check("reset_valid", frame_valid, 0);
    rst = 1;
    repeat (5) @(negedge clk);

    // Write-and-update one channel
    do_frame(24, 64'h321234);
    check("lit_dac2", {48'h0, dac[2]}, 64'h1234);
    check("lit_dac1", {48'h0, dac[1]}, 64'h8000);

    // Input register only, then update, then broadcast
    do_frame(24, 64'h05ABCD);
    check("lit_dac5_held", {48'h0, dac[5]}, 64'h8000);
    do_frame(24, 64'h150000);
    check("lit_dac5_upd", {48'h0, dac[5]}, 64'hABCD);
    do_frame(24, 64'hA00001);
    check("lit_dac0_all", {48'h0, dac[0]}, 64'h0001);
    check("lit_dac7_all", {48'h0, dac[7]}, 64'h0001);

    // Echo of frame A on SDO during frame B
    do_frame(24, 64'h317FFF);
    do_frame(24, 64'h0F0000);
    check("lit_echo", last_got, 64'h317FFF);

    // Framing errors, including counter saturation and CS glitch
    do_frame(23, 64'h321111);
    do_frame(25, 64'h0642222);
    check("lit_err2", err_count, 2);
    check("lit_dac2_kept", {48'h0, dac[2]}, 64'h0001);
    do_frame(56, {32'h0, 24'h3_1_5555} << 8);
    do_frame(-1, 64'h0);
    do_frame(0, 64'h0);
    for (int i = 0; i < 300; i++) do_frame($urandom_range(0, 3), 64'($urandom));
    check("lit_err_sat", err_count, 255);

    // Power-down control
    do_frame(24, 64'h430000);
    check("lit_pd_08", pd, 8'h08);
    do_frame(24, 64'h500000);
    check("lit_pd_ff", pd, 8'hFF);
    do_frame(24, 64'h900000);
    check("lit_pd_00", pd, 8'h00);

    // Reset mid-frame
    begin
      int v0, e0;
      v0 = vcnt; e0 = ecnt;
      @(negedge clk);
      cs_n = 0;
      for (int i = 0; i < 12; i++) begin
        sdi = 1'($urandom);
        repeat (HALF) @(negedge clk);
        sck = 1;
        repeat (HALF) @(negedge clk);
        sck = 0;
      end
      rst = 0;
      repeat (2) @(negedge clk);
      cs_n = 1;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (8) @(negedge clk);
      check("rst_mid_valid", vcnt - v0, 0);
      check("rst_mid_err", ecnt - e0, 0);
      check("rst_mid_dac3", {48'h0, dac[3]}, 64'h8000);
      check("rst_mid_errcnt", err_count, 0);
    end
    do_frame(24, 64'h37BEEF);
    check("lit_post_rst", {48'h0, dac[7]}, 64'hBEEF);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      c  = ($urandom_range(0, 9) == 9) ? 4'($urandom) : cmds[$urandom_range(0, 8)];
      nb = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 23 : 25) : 24;
      do_frame(nb, {40'h0, c, 4'($urandom_range(0, 15)), 16'($urandom)});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
